// File: rtl/writeback_commit.sv
// writeback_commit: final pipeline stage. Latches the mem/wb bundle, commits it
// to the register file and the CZ flag register once per instruction, and
// publishes wb / post-wb tags for the execute-stage forwarding unit.
//
// Stage handshake: stall_in=1 holds the latched bundle and clears 'fresh', so a
// bundle commits only in its first cycle of occupancy. stall_in=0 accepts the
// incoming bundle on every edge, whether or not valid_in is set. There is no
// back-pressure towards the register file.
module writeback_commit #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [5:0]        op_in,
  input  logic [REG_AW-1:0] regA_in,
  input  logic [REG_AW-1:0] regB_in,
  input  logic [REG_AW-1:0] regC_in,
  input  logic [DATA_W-1:0] alu_in,
  input  logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] pc1_in,
  input  logic              nullify_in,
  input  logic [1:0]        cz_in,
  input  logic              stall_in,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              r7_we,
  output logic [1:0]        cz_out,
  output logic              cz_we,
  output logic [5:0]        wb_op,
  output logic [REG_AW-1:0] wb_regA,
  output logic [REG_AW-1:0] wb_regB,
  output logic [REG_AW-1:0] wb_regC,
  output logic [5:0]        wbpr_op,
  output logic [REG_AW-1:0] wbpr_regA,
  output logic [REG_AW-1:0] wbpr_regB,
  output logic [REG_AW-1:0] wbpr_regC,
  output logic              wbpr_cz_we,
  output logic [CNT_W-1:0]  retired
);

  // Latched bundle
  logic              valid_q, fresh_q, nullify_q;
  logic [5:0]        op_q;
  logic [REG_AW-1:0] rega_q, regb_q, regc_q;
  logic [DATA_W-1:0] alu_q, mem_q, pc1_q;
  logic [1:0]        czin_q;

  // Architectural state and post-wb tags
  logic [1:0]        cz_q, cz_d;
  logic [CNT_W-1:0]  retired_q;
  logic [5:0]        wbpr_op_q;
  logic [REG_AW-1:0] wbpr_rega_q, wbpr_regb_q, wbpr_regc_q;
  logic              wbpr_cz_we_q;

  // Decode results
  logic              commit;
  logic              writes_rf;
  logic              wr_z, wr_c;
  logic              z_val;
  logic [REG_AW-1:0] dest;
  logic [DATA_W-1:0] wdata;

  // Capture the bundle when not stalled; a held bundle is never fresh again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= 1'b0;
      fresh_q   <= 1'b0;
      nullify_q <= 1'b0;
      op_q      <= '0;
      rega_q    <= '0;
      regb_q    <= '0;
      regc_q    <= '0;
      alu_q     <= '0;
      mem_q     <= '0;
      pc1_q     <= '0;
      czin_q    <= '0;
    end else if (!stall_in) begin
      valid_q   <= valid_in;
      fresh_q   <= valid_in;
      nullify_q <= nullify_in;
      op_q      <= op_in;
      rega_q    <= regA_in;
      regb_q    <= regB_in;
      regc_q    <= regC_in;
      alu_q     <= alu_in;
      mem_q     <= mem_in;
      pc1_q     <= pc1_in;
      czin_q    <= cz_in;
    end else begin
      fresh_q   <= 1'b0;
    end
  end

  // Decode destination, write data and flag-update rules from the opcode.
  always_comb begin
    writes_rf = 1'b0;
    dest      = regc_q;
    wdata     = alu_q;
    wr_z      = 1'b0;
    wr_c      = 1'b0;
    z_val     = czin_q[1];
    unique case (op_q[5:2])
      4'b0000: begin writes_rf = 1'b1; dest = regc_q; wdata = alu_q; wr_z = 1'b1; wr_c = 1'b1; end
      4'b0010: begin writes_rf = 1'b1; dest = regc_q; wdata = alu_q; wr_z = 1'b1; end
      4'b0001: begin writes_rf = 1'b1; dest = regb_q; wdata = alu_q; wr_z = 1'b1; wr_c = 1'b1; end
      4'b0011: begin writes_rf = 1'b1; dest = rega_q; wdata = alu_q; end
      4'b0100: begin
        writes_rf = 1'b1; dest = rega_q; wdata = mem_q;
        wr_z = 1'b1; z_val = (mem_q == '0);
      end
      4'b1000, 4'b1001: begin writes_rf = 1'b1; dest = rega_q; wdata = pc1_q; end
      default: ;
    endcase
  end

  // Commit strobes and next CZ value.
  always_comb begin
    commit = valid_q & fresh_q & ~nullify_q;
    cz_we  = commit & (wr_z | wr_c);
    cz_d   = cz_q;
    if (commit && wr_z) cz_d[1] = z_val;
    if (commit && wr_c) cz_d[0] = czin_q[0];
  end

  // CZ register, retired counter and post-wb tags advance every edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cz_q         <= 2'b00;
      retired_q    <= '0;
      wbpr_op_q    <= '0;
      wbpr_rega_q  <= '0;
      wbpr_regb_q  <= '0;
      wbpr_regc_q  <= '0;
      wbpr_cz_we_q <= 1'b0;
    end else begin
      cz_q         <= cz_d;
      if (commit) retired_q <= retired_q + CNT_W'(1);
      wbpr_op_q    <= op_q;
      wbpr_rega_q  <= rega_q;
      wbpr_regb_q  <= regb_q;
      wbpr_regc_q  <= regc_q;
      wbpr_cz_we_q <= cz_we;
    end
  end

  assign rf_we      = commit & writes_rf;
  assign rf_addr    = dest;
  assign rf_data    = wdata;
  assign r7_we      = rf_we & (dest == REG_AW'(7));
  assign cz_out     = cz_q;
  assign wb_op      = op_q;
  assign wb_regA    = rega_q;
  assign wb_regB    = regb_q;
  assign wb_regC    = regc_q;
  assign wbpr_op    = wbpr_op_q;
  assign wbpr_regA  = wbpr_rega_q;
  assign wbpr_regB  = wbpr_regb_q;
  assign wbpr_regC  = wbpr_regc_q;
  assign wbpr_cz_we = wbpr_cz_we_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_writeback_commit.sv
// tb_writeback_commit: randomized and directed stimulus for writeback_commit,
// with an instruction-level reference model feeding an expected-output queue
// that a negedge monitor drains.
module tb_writeback_commit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        valid_in = 0, nullify_in = 0, stall_in = 0;
  logic [5:0]  op_in = '0;
  logic [2:0]  regA_in = '0, regB_in = '0, regC_in = '0;
  logic [15:0] alu_in = '0, mem_in = '0, pc1_in = '0;
  logic [1:0]  cz_in = '0;

  logic        rf_we, r7_we, cz_we, wbpr_cz_we;
  logic [2:0]  rf_addr, wb_regA, wb_regB, wb_regC, wbpr_regA, wbpr_regB, wbpr_regC;
  logic [15:0] rf_data, retired;
  logic [1:0]  cz_out;
  logic [5:0]  wb_op, wbpr_op;

  writeback_commit #(.DATA_W(16), .REG_AW(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .op_in(op_in),
    .regA_in(regA_in), .regB_in(regB_in), .regC_in(regC_in),
    .alu_in(alu_in), .mem_in(mem_in), .pc1_in(pc1_in),
    .nullify_in(nullify_in), .cz_in(cz_in), .stall_in(stall_in),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .r7_we(r7_we),
    .cz_out(cz_out), .cz_we(cz_we),
    .wb_op(wb_op), .wb_regA(wb_regA), .wb_regB(wb_regB), .wb_regC(wb_regC),
    .wbpr_op(wbpr_op), .wbpr_regA(wbpr_regA), .wbpr_regB(wbpr_regB),
    .wbpr_regC(wbpr_regC), .wbpr_cz_we(wbpr_cz_we), .retired(retired)
  );

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        rf_we;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        r7;
    logic        cz_we;
    logic [1:0]  cz;
    logic [15:0] ret;
    logic [14:0] wb_tag;
    logic [14:0] wbpr_tag;
    logic        wbpr_cz_we;
  } rec_t;

  rec_t exp_q[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (instruction level) ----------------
  typedef struct packed {
    logic        valid;
    logic [5:0]  op;
    logic [2:0]  a, b, c;
    logic [15:0] alu, mem, pc1;
    logic        nul;
    logic [1:0]  cz;
  } instr_t;

  instr_t      m_stage;
  logic        m_fresh;
  logic [1:0]  m_cz;
  logic [15:0] m_ret;
  logic        p_commit, p_cz_we;
  logic [1:0]  p_cz_new;

  task automatic model_reset();
    m_stage = '0; m_fresh = 0; m_cz = 2'b00; m_ret = 16'h0;
    p_commit = 0; p_cz_we = 0; p_cz_new = 2'b00;
  endtask

  // One clock edge of the architectural model; pushes what the stage shows afterwards.
  task automatic model_step();
    rec_t        r;
    logic        commit, wr;
    logic [2:0]  dest;
    logic [15:0] data;
    logic        flags;
    logic [1:0]  cz_new;
    // Retire what committed during the previous cycle.
    if (p_cz_we) m_cz = p_cz_new;
    if (p_commit) m_ret = m_ret + 16'd1;
    r = '0;
    r.wbpr_tag   = {m_stage.op, m_stage.a, m_stage.b, m_stage.c};
    r.wbpr_cz_we = p_cz_we;
    if (!stall_in) begin
      m_stage = '{valid_in, op_in, regA_in, regB_in, regC_in, alu_in, mem_in, pc1_in, nullify_in, cz_in};
      m_fresh = valid_in;
    end else begin
      m_fresh = 0;
    end
    commit = m_stage.valid && m_fresh && !m_stage.nul;
    wr = 1; dest = 0; data = 0;
    case (m_stage.op[5:2])
      4'b0000, 4'b0010: begin dest = m_stage.c; data = m_stage.alu; end // ADD/ADC/ADZ, NDU/NDC/NDZ
      4'b0001:          begin dest = m_stage.b; data = m_stage.alu; end // ADI
      4'b0011:          begin dest = m_stage.a; data = m_stage.alu; end // LHI
      4'b0100:          begin dest = m_stage.a; data = m_stage.mem; end // LW
      4'b1000, 4'b1001: begin dest = m_stage.a; data = m_stage.pc1; end // JAL/JLR
      default: wr = 0;
    endcase
    flags = 1; cz_new = m_cz;
    case (m_stage.op[5:2])
      4'b0000, 4'b0001: cz_new = m_stage.cz;
      4'b0010:          cz_new = {m_stage.cz[1], m_cz[0]};
      4'b0100:          cz_new = {(m_stage.mem == 16'h0), m_cz[0]};
      default:          flags = 0;
    endcase
    r.rf_we  = commit && wr;
    r.addr   = dest;
    r.data   = data;
    r.r7     = commit && wr && (dest == 3'd7);
    r.cz_we  = commit && flags;
    r.cz     = m_cz;
    r.ret    = m_ret;
    r.wb_tag = {m_stage.op, m_stage.a, m_stage.b, m_stage.c};
    exp_q.push_back(r);
    p_commit = commit;
    p_cz_we  = commit && flags;
    p_cz_new = cz_new;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (exp_q.size() > 0) begin
        rec_t e;
        e = exp_q.pop_front();
        chk("rf_we", rf_we, e.rf_we);
        if (e.rf_we) begin
          chk("rf_addr", rf_addr, e.addr);
          chk("rf_data", rf_data, e.data);
        end
        chk("r7_we", r7_we, e.r7);
        chk("cz_we", cz_we, e.cz_we);
        chk("cz_out", cz_out, e.cz);
        chk("retired", retired, e.ret);
        chk("wb_tag", {wb_op, wb_regA, wb_regB, wb_regC}, e.wb_tag);
        chk("wbpr_tag", {wbpr_op, wbpr_regA, wbpr_regB, wbpr_regC}, e.wbpr_tag);
        chk("wbpr_cz_we", wbpr_cz_we, e.wbpr_cz_we);
      end else begin
        chk("idle_rf_we", rf_we, 1'b0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [5:0] op, input logic [2:0] a, b, c,
                       input logic [15:0] alu, mem, pc1, input logic nul,
                       input logic [1:0] cz, input logic stl);
    valid_in = v; op_in = op; regA_in = a; regB_in = b; regC_in = c;
    alu_in = alu; mem_in = mem; pc1_in = pc1; nullify_in = nul; cz_in = cz; stall_in = stl;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    drive(0, 6'd0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 2'b00, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rf_we"}, rf_we, 0);
    chk({tag, "_r7_we"}, r7_we, 0);
    chk({tag, "_cz_we"}, cz_we, 0);
    chk({tag, "_cz_out"}, cz_out, 0);
    chk({tag, "_retired"}, retired, 0);
    chk({tag, "_wb_tag"}, {wb_op, wb_regA, wb_regB, wb_regC}, 0);
    chk({tag, "_wbpr"}, {wbpr_op, wbpr_regA, wbpr_regB, wbpr_regC, wbpr_cz_we}, 0);
  endtask

  logic [5:0] legal_ops [11] = '{6'b000000, 6'b000010, 6'b000001, 6'b000100, 6'b001000,
                                  6'b001100, 6'b010000, 6'b010100, 6'b110000, 6'b100000, 6'b100100};

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1;

    // ADD r3 = 0, flags 11
    drive(1, 6'b000000, 3'd1, 3'd2, 3'd3, 16'h0000, 16'h1234, 16'h0010, 0, 2'b11, 0);
    chk("t1_rf_we", rf_we, 1);
    chk("t1_addr", rf_addr, 3);
    chk("t1_data", rf_data, 16'h0000);
    idle();
    chk("t1_cz", cz_out, 2'b11);
    chk("t1_ret", retired, 1);

    // ADC nullified: nothing written, tag still visible
    drive(1, 6'b000010, 3'd1, 3'd2, 3'd4, 16'h5555, 16'h0, 16'h0, 1, 2'b00, 0);
    chk("t2_rf_we", rf_we, 0);
    chk("t2_cz_we", cz_we, 0);
    chk("t2_wb_op", wb_op, 6'b000010);
    idle();
    chk("t2_cz", cz_out, 2'b11);
    chk("t2_ret", retired, 1);

    // ADI sets CZ=01, then LW of zero sets Z, then NDU holds C
    drive(1, 6'b000100, 3'd0, 3'd6, 3'd0, 16'h0007, 16'h0, 16'h0, 0, 2'b01, 0);
    drive(1, 6'b010000, 3'd5, 3'd1, 3'd0, 16'h0009, 16'h0000, 16'h0, 0, 2'b00, 0);
    chk("t3_lw_addr", rf_addr, 5);
    chk("t3_lw_data", rf_data, 16'h0000);
    chk("t3_pre_cz", cz_out, 2'b01);
    drive(1, 6'b001000, 3'd1, 3'd2, 3'd6, 16'h00F0, 16'h0, 16'h0, 0, 2'b00, 0);
    chk("t3_lw_cz", cz_out, 2'b11);
    idle();
    chk("t3_ndu_cz", cz_out, 2'b01);

    // JAL to R7 then 3 stalled cycles: strobes once, retired +1
    drive(1, 6'b100000, 3'd7, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0041, 0, 2'b00, 0);
    chk("t4_r7_we", r7_we, 1);
    chk("t4_data", rf_data, 16'h0041);
    repeat (3) begin
      drive(1, 6'b000000, 3'd1, 3'd1, 3'd1, 16'hBEEF, 16'h0, 16'h0, 0, 2'b10, 1);
      chk("t4_stall_we", rf_we, 0);
    end
    idle();
    chk("t4_ret", retired, 16'd5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [5:0] op;
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 10)];
      drive($urandom_range(0, 9) != 0, op, 3'($urandom), 3'($urandom), 3'($urandom),
            16'($urandom), ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom), 16'($urandom),
            $urandom_range(0, 4) == 0, 2'($urandom), $urandom_range(0, 4) == 0);
    end
    idle();

    // Counter wrap: run up to 0xFFFF, then one more ADD
    while (m_ret + 16'(p_commit) != 16'hFFFF)
      drive(1, 6'b000000, 3'd1, 3'd2, 3'($urandom), 16'($urandom), 16'h0, 16'h0, 0, 2'($urandom), 0);
    idle();
    chk("t5_ret_max", retired, 16'hFFFF);
    drive(1, 6'b000000, 3'd1, 3'd2, 3'd3, 16'h0001, 16'h0, 16'h0, 0, 2'b00, 0);
    idle();
    chk("t5_ret_wrap", retired, 16'h0000);

    // Asynchronous reset while an LW is latched
    drive(1, 6'b010000, 3'd2, 3'd0, 3'd0, 16'h0, 16'h0005, 16'h0, 0, 2'b00, 0);
    chk("t6_pre_we", rf_we, 1);
    #1;
    reset = 0;
    exp_q.delete();
    model_reset();
    #1;
    check_all_zero("t6_async");
    chk("t6_rf_data", rf_data, 16'h0);
    @(posedge clk);
    #1;
    reset = 1;
    drive(1, 6'b000000, 3'd1, 3'd2, 3'd6, 16'h00AA, 16'h0, 16'h0, 0, 2'b10, 0);
    chk("t6_add_we", rf_we, 1);
    chk("t6_add_addr", rf_addr, 6);
    idle();
    chk("t6_ret", retired, 1);
    chk("t6_cz", cz_out, 2'b10);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
